// File: rtl/alu_issue_stage.sv
// Operand-issue, execute and writeback stage wrapped around the 12-bit ALU.
// Owns a small register file and forwards the in-flight result so that dependent ops issue back-to-back.
module alu_issue_stage #(
    parameter int DATA_W = 12,
    parameter int NREG   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // in_valid/in_ready: an op transfers on any cycle where both are high.
    // in_ready depends only on stall, never on in_valid, so there is no combinational loop.
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [$clog2(NREG)-1:0]   in_rd,
    input  logic [$clog2(NREG)-1:0]   in_rs,
    input  logic [$clog2(NREG)-1:0]   in_rt,
    input  logic                      in_use_imm,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic                      stall,
    output logic [DATA_W-1:0]         alu_srca,
    output logic [DATA_W-1:0]         alu_srcb,
    output logic [2:0]                alu_ctrl,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    output logic                      wb_valid,
    output logic [$clog2(NREG)-1:0]   wb_rd,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      cmp_valid,
    output logic                      cmp_equal
);

    localparam int AW = $clog2(NREG);
    localparam logic [2:0] OP_CMP = 3'b110;

    function automatic logic op_writes(input logic [2:0] op);
        return (op >= 3'b001) && (op <= 3'b101);
    endfunction

    function automatic logic op_is_nop(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b111);
    endfunction

    logic [DATA_W-1:0] rf_q [NREG];

    logic              e_valid_q;
    logic [2:0]        e_op_q;
    logic [AW-1:0]     e_rd_q;
    logic [DATA_W-1:0] srca_q, srcb_q;

    logic              wb_valid_q;
    logic [AW-1:0]     wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              cmp_valid_q;
    logic              cmp_equal_q;

    logic              accept;
    logic              e_fwd;
    logic [DATA_W-1:0] opa_d, opb_d;

    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    // r0 is never a forwarding source, so a write to r0 can never leak into a reader.
    assign e_fwd    = e_valid_q && op_writes(e_op_q) && (e_rd_q != '0);

    always_comb begin
        opa_d = (in_rs == '0) ? '0 : rf_q[in_rs];
        opb_d = (in_rt == '0) ? '0 : rf_q[in_rt];
        if (e_fwd && (e_rd_q == in_rs)) opa_d = alu_result;
        if (e_fwd && (e_rd_q == in_rt)) opb_d = alu_result;
        if (in_use_imm)                 opb_d = in_imm;
    end

    // Execute register: reloaded on every non-stall cycle; NOPs travel with ctrl 000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q <= 1'b0;
            e_op_q    <= 3'b000;
            e_rd_q    <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
        end else if (!stall) begin
            e_valid_q <= accept;
            e_op_q    <= (accept && !op_is_nop(in_op)) ? in_op : 3'b000;
            e_rd_q    <= accept ? in_rd : '0;
            srca_q    <= accept ? opa_d : '0;
            srcb_q    <= accept ? opb_d : '0;
        end
    end

    // Writeback: pulses are held through a stall and revealed once it drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            cmp_valid_q <= 1'b0;
            cmp_equal_q <= 1'b0;
        end else if (!stall) begin
            wb_valid_q  <= e_valid_q && op_writes(e_op_q);
            cmp_valid_q <= e_valid_q && (e_op_q == OP_CMP);
            if (e_valid_q && op_writes(e_op_q)) begin
                wb_rd_q   <= e_rd_q;
                wb_data_q <= alu_result;
                if (e_rd_q != '0) rf_q[e_rd_q] <= alu_result;
            end
            if (e_valid_q && (e_op_q == OP_CMP)) cmp_equal_q <= alu_zero;
        end
    end

    assign alu_srca  = srca_q;
    assign alu_srcb  = srcb_q;
    assign alu_ctrl  = e_op_q;
    assign wb_valid  = wb_valid_q && !stall;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign cmp_valid = cmp_valid_q && !stall;
    assign cmp_equal = cmp_equal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized stream against an architectural model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_rd, in_rs, in_rt;
    logic        in_use_imm;
    logic [11:0] in_imm;
    logic        stall;
    logic [11:0] alu_srca, alu_srcb;
    logic [2:0]  alu_ctrl;
    logic [11:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [11:0] wb_data;
    logic        cmp_valid;
    logic        cmp_equal;

    int total = 0;
    int bad   = 0;

    logic [14:0] exp_q[$];
    logic [11:0] m_rf [4];

    alu_issue_stage #(.DATA_W(12), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .stall(stall),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .cmp_valid(cmp_valid), .cmp_equal(cmp_equal)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        case (op)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return a - b;
            default: return 12'h000;
        endcase
    endfunction

    // Environment ALU
    always_comb begin
        alu_result = alu_f(alu_ctrl, alu_srca, alu_srcb);
        alu_zero   = (alu_result == 12'h000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [1:0] rt, input logic ui, input logic [11:0] imm);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_use_imm = ui; in_imm = imm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({alu_srca, alu_srcb, alu_ctrl, wb_valid, wb_rd, wb_data, cmp_valid, cmp_equal} !== 44'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {alu_srca, alu_srcb, alu_ctrl, wb_valid, wb_rd, wb_data, cmp_valid, cmp_equal});
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step(); rst_n = 1'b1; step();
        // Reset with an ADD sitting in the execute stage
        drive_op(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 12'h005);
        rst_n = 1'b0;
        #1;
        total++;
        if ({alu_srca, alu_srcb, alu_ctrl, wb_valid, cmp_valid} !== 29'h0) begin
            bad++; $display("FAIL reset_mid got=%h exp=0", {alu_srca, alu_srcb, alu_ctrl, wb_valid, cmp_valid});
        end
        step(); rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_no_wb got=%b exp=0", wb_valid); end
        end
        drive_op(3'b001, 2'd2, 2'd1, 2'd0, 1'b1, 12'h000);
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd2, 12'h000}) begin
            bad++; $display("FAIL reset_r1_zero got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd2, 12'h000});
        end
    endtask

    task automatic test_imm_add();
        drive_op(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 12'h005);
        total++;
        if ({alu_srca, alu_srcb, alu_ctrl} !== {12'h000, 12'h005, 3'b001}) begin
            bad++; $display("FAIL add_alu got=%h exp=%h", {alu_srca, alu_srcb, alu_ctrl}, {12'h000, 12'h005, 3'b001});
        end
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 12'h005}) begin
            bad++; $display("FAIL add_wb got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd1, 12'h005});
        end
        step();
        total++;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL add_pulse_once got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        drive_op(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 12'h005);
        drive_op(3'b010, 2'd2, 2'd1, 2'd0, 1'b1, 12'h007);
        total++;
        if ({alu_srca, alu_srcb, alu_ctrl} !== {12'h005, 12'h007, 3'b010}) begin
            bad++; $display("FAIL fwd_alu got=%h exp=%h", {alu_srca, alu_srcb, alu_ctrl}, {12'h005, 12'h007, 3'b010});
        end
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd2, 12'hFFE}) begin
            bad++; $display("FAIL fwd_wb got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd2, 12'hFFE});
        end
    endtask

    task automatic test_cmp();
        drive_op(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 12'h0A5);
        drive_op(3'b001, 2'd2, 2'd0, 2'd0, 1'b1, 12'h0A5);
        drive_op(3'b110, 2'd3, 2'd1, 2'd2, 1'b0, 12'h000);
        step();
        total++;
        if ({cmp_valid, cmp_equal, wb_valid} !== 3'b110) begin
            bad++; $display("FAIL cmp_equal got=%b exp=110", {cmp_valid, cmp_equal, wb_valid});
        end
        step();
        total++;
        if ({cmp_valid, cmp_equal} !== 2'b01) begin
            bad++; $display("FAIL cmp_hold got=%b exp=01", {cmp_valid, cmp_equal});
        end
        drive_op(3'b110, 2'd0, 2'd1, 2'd0, 1'b0, 12'h000);
        step();
        total++;
        if ({cmp_valid, cmp_equal, wb_valid} !== 3'b100) begin
            bad++; $display("FAIL cmp_unequal got=%b exp=100", {cmp_valid, cmp_equal, wb_valid});
        end
    endtask

    task automatic test_r0_nop();
        drive_op(3'b101, 2'd0, 2'd0, 2'd0, 1'b1, 12'hFFF);
        drive_op(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 12'h000);
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd0, 12'hFFF}) begin
            bad++; $display("FAIL r0_wb got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd0, 12'hFFF});
        end
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 12'h000}) begin
            bad++; $display("FAIL r0_reads_zero got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd1, 12'h000});
        end
        drive_op(3'b111, 2'd1, 2'd1, 2'd1, 1'b0, 12'h123);
        total++;
        if (alu_ctrl !== 3'b000) begin bad++; $display("FAIL nop_ctrl got=%b exp=000", alu_ctrl); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({wb_valid, cmp_valid} !== 2'b00) begin
                bad++; $display("FAIL nop_pulse got=%b exp=00", {wb_valid, cmp_valid});
            end
        end
    endtask

    task automatic test_stall();
        drive_op(3'b100, 2'd3, 2'd0, 2'd0, 1'b1, 12'h03C);
        stall = 1'b1;
        in_valid = 1'b1; in_op = 3'b001; in_rd = 2'd3; in_rs = 2'd0; in_use_imm = 1'b1; in_imm = 12'h777;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({alu_srca, alu_srcb, alu_ctrl, wb_valid} !== {12'h000, 12'h03C, 3'b100, 1'b0}) begin
                bad++; $display("FAIL stall_hold got=%h exp=%h", {alu_srca, alu_srcb, alu_ctrl, wb_valid}, {12'h000, 12'h03C, 3'b100, 1'b0});
            end
        end
        stall = 1'b0; in_valid = 1'b0;
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd3, 12'h03C}) begin
            bad++; $display("FAIL stall_wb got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd3, 12'h03C});
        end
        step();
        total++;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL stall_single_pulse got=%b exp=0", wb_valid); end
        drive_op(3'b001, 2'd1, 2'd3, 2'd0, 1'b1, 12'h000);
        step();
        total++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 12'h03C}) begin
            bad++; $display("FAIL stall_r3 got=%h exp=%h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd1, 12'h03C});
        end
    endtask

    task automatic check_retire();
        logic [14:0] act, expv;
        total++;
        if (stall && (wb_valid || cmp_valid)) begin
            bad++; $display("FAIL rand_pulse_in_stall got=%b exp=00", {wb_valid, cmp_valid});
        end
        if (wb_valid || cmp_valid) begin
            act = cmp_valid ? {1'b1, 13'h0, cmp_equal} : {1'b0, wb_rd, wb_data};
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL rand_unexpected got=%h exp=none", act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin bad++; $display("FAIL rand_retire got=%h exp=%h", act, expv); end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] a, b, r;
        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0;
        step(); rst_n = 1'b1; step();
        for (int i = 0; i < 4; i++) m_rf[i] = 12'h000;
        exp_q.delete();
        for (int c = 0; c < 1500; c++) begin
            stall      = ($urandom_range(0, 4) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 3'($urandom_range(0, 7));
            in_rd      = 2'($urandom_range(0, 3));
            in_rs      = 2'($urandom_range(0, 3));
            in_rt      = 2'($urandom_range(0, 3));
            in_use_imm = 1'($urandom_range(0, 1));
            in_imm     = 12'($urandom);
            @(negedge clk);
            total++;
            if (in_ready !== !stall) begin bad++; $display("FAIL rand_ready got=%b exp=%b", in_ready, !stall); end
            check_retire();
            if (in_valid && !stall) begin
                a = m_rf[in_rs];
                b = in_use_imm ? in_imm : m_rf[in_rt];
                r = alu_f(in_op, a, b);
                if (in_op >= 3'b001 && in_op <= 3'b101) begin
                    if (in_rd != 2'd0) m_rf[in_rd] = r;
                    exp_q.push_back({1'b0, in_rd, r});
                end else if (in_op == 3'b110) begin
                    exp_q.push_back({1'b1, 13'h0, (r == 12'h000)});
                end
            end
            step();
        end
        stall = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_retire();
            step();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; in_op = 3'b000;
        in_rd = 2'd0; in_rs = 2'd0; in_rt = 2'd0; in_use_imm = 1'b0; in_imm = 12'h000;
        test_reset();
        test_imm_add();
        test_back_to_back();
        test_cmp();
        test_r0_nop();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage wrapped around the 12-bit ALU of the CPU datapath. Accepts decoded register-to-register or register-immediate operations over a valid/ready handshake and reads operands from a 4-entry, 12-bit register file it owns. It drives SrcA/SrcB/Control_in to the ALU through a registered execute stage, then captures ALUResult and zero into a writeback register. It provides a one-cycle result-forwarding path so that back-to-back dependent operations issue without bubbles.

## Interface
- DATA_W, 12, datapath width (must match ALU width)
- NREG, 4, register count; r0 reads as zero
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded operation present
- in_ready  out  1  stage can accept; equals !stall
- in_op  in  3  ALU opcode (001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 CMP; 000/111 NOP)
- in_rd  in  2  destination register
- in_rs  in  2  source A register
- in_rt  in  2  source B register
- in_use_imm  in  1  1: SrcB = in_imm instead of reg[in_rt]
- in_imm  in  12  immediate operand
- stall  in  1  downstream hold; freezes execute stage
- alu_srca  out  12  to ALU SrcA (registered)
- alu_srcb  out  12  to ALU SrcB (registered)
- alu_ctrl  out  3  to ALU Control_in (registered)
- alu_result  in  12  from ALU ALUResult (combinational)
- alu_zero  in  1  from ALU zero
- wb_valid  out  1  one-cycle pulse: a register was written
- wb_rd  out  2  register written
- wb_data  out  12  value written
- cmp_valid  out  1  one-cycle pulse: CMP completed
- cmp_equal  out  1  CMP result (alu_zero), held until next CMP

## Operation
- Accept: in_valid && in_ready. Opcodes 000 and 111 are accepted and retire as NOPs: no register write, no cmp pulse, alu_ctrl = 000.
- Operand read at accept: A = reg[in_rs], B = in_use_imm ? in_imm : reg[in_rt]; r0 always reads 12'h000.
- Forwarding: if E-stage is valid, writes (op 001–101), E.rd != 0, and E.rd matches in_rs (or in_rt when !in_use_imm), the operand is taken from alu_result instead of the register file.
- Execute (E) register: e_valid, e_op, e_rd, srca, srcb; drives alu_* directly. Loaded on every cycle with !stall; with no accept, e_valid = 0 and alu_ctrl = 000.
- Writeback at E-advance (!stall && e_valid): ops 001–101 write alu_result to reg[e_rd] (ignored for e_rd = 0, but wb_valid still pulses with wb_rd = 0, wb_data = alu_result). Op 110 writes no register; it pulses cmp_valid and loads cmp_equal = alu_zero.
- Stall: E register, register file, and wb/cmp outputs hold; no writes occur. wb_valid and cmp_valid are 0 during stall cycles (each retirement pulses exactly once).
- Arithmetic is modulo 2^12 (the ALU wraps); this block performs no width extension.

## Timing
- Reset (async assert, sync-to-clk deassert by the system): registers r0–r3 = 0, e_valid = 0, alu_srca = alu_srcb = 0, alu_ctrl = 000, wb_valid = 0, wb_rd = 0, wb_data = 0, cmp_valid = 0, cmp_equal = 0. in_ready follows stall immediately. Reset mid-operation discards the in-flight E op with no write.
- Accept in cycle N -> alu_* valid throughout cycle N+1 -> register file written on the N+1/N+2 edge -> wb_valid/cmp_valid high in cycle N+2.
- Throughput: one op per cycle with no stall; a dependent op accepted in N+1 gets the forwarded value; in N+2 or later it reads the register file.
- Stall asserted in cycle M: in_ready = 0 in M; E content unchanged at the M edge.

## Test plan
- Reset: assert rst_n = 0 mid-stream -> all outputs at reset values in the same cycle; regs read 0 afterwards; no wb_valid.
- Immediate ADD: ADD r1 = r0 + imm 12'h005 -> alu_srca = 0, alu_srcb = 5, alu_ctrl = 001 at N+1; wb_valid, wb_rd = 1, wb_data = 12'h005 at N+2.
- Back-to-back forward: r1 = 5, then SUB r2 = r1 - imm 7 in the next cycle -> alu_srca = 5 (forwarded), wb_data = 12'hFFE (wrap).
- CMP: r1 = 12'h0A5, r2 = 12'h0A5, CMP r1, r2 -> cmp_valid pulse, cmp_equal = 1, no wb_valid; then CMP r1, r0 -> cmp_equal = 0.
- r0 write and NOP: XOR r0 = imm 12'hFFF -> wb_valid, wb_rd = 0, but r0 still reads 0; op 111 -> no pulses at all.
- Stall: issue OR r3, then hold stall = 1 for 3 cycles -> in_ready = 0, alu_* stable, single wb_valid pulse only after stall drops, r3 written once.
